wb_scoreboard: RTL and testbench
================================

Name: wb_scoreboard

Overview:
- Write-back stage of the multi-cycle MIPS CPU.
- Sits directly upstream of the register file and drives its write port (RegWre, WriteReg, WriteData).
- Selects the write-back source and destination register, then registers the write for one cycle.
- Keeps a 32-entry pending-write scoreboard so decode can stall on operands whose producer has not yet written back.

Parameters:
DATA_W, 32, data path width
ADDR_W, 5, register index width (32 registers)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
iss_en  in  1  decode allocates a destination this cycle
iss_reg  in  ADDR_W  destination being allocated
wb_valid  in  1  write-back request
wb_ready  out  1  stage can accept a request
wb_sel  in  2  source: 00 ALU result, 01 memory data, 10 PC+4, 11 reserved
wb_dst_sel  in  2  destination: 00 rt, 01 rd, 10 $31, 11 reserved
rt  in  ADDR_W  instruction rt field
rd  in  ADDR_W  instruction rd field
alu_res  in  DATA_W  ALU result
mem_data  in  DATA_W  data memory read data
pc4  in  DATA_W  PC+4
RegWre  out  1  register file write enable
WriteReg  out  ADDR_W  register file write index
WriteData  out  DATA_W  register file write data
rs_q  in  ADDR_W  decode operand query 1
rt_q  in  ADDR_W  decode operand query 2
rs_busy  out  1  mask[rs_q]
rt_busy  out  1  mask[rt_q]
pend_mask  out  32  scoreboard, bit n = register n pending
retire_cnt  out  32  count of committed write-backs
err  out  1  sticky protocol error

Behaviour:
- Reset (RST low, asynchronous): RegWre=0, WriteReg=0, WriteData=0, pend_mask=0, retire_cnt=0, err=0, state IDLE. Reset mid-write aborts the write; no partial state survives.
- Two states, IDLE and COMMIT:
  - IDLE -> COMMIT on wb_valid && wb_ready.
  - COMMIT -> COMMIT if a new request is accepted in the same cycle; otherwise COMMIT -> IDLE.
- wb_ready is 1 in both states. Back-to-back accepts are legal, so throughput is one write per cycle.
- Accept at edge E:
  - Destination = rt / rd / 31 per wb_dst_sel.
  - Data = alu_res / mem_data / pc4 per wb_sel.
  - Both are registered into WriteReg/WriteData at E.
  - RegWre is 1 during cycle E..E+1 only if the destination is nonzero; otherwise 0.
  - The register file writes at E+1.
- Latency: request to register-file update is 2 edges; request to output visibility is 1 edge.
- Reserved encodings (wb_sel=11 or wb_dst_sel=11): request is accepted, RegWre is held 0, err is set.
- Scoreboard:
  - iss_en with iss_reg!=0 sets pend_mask[iss_reg] at the next edge. iss_reg=0 is ignored, so bit 0 is always 0.
  - A commit clears pend_mask[WriteReg] at edge E+1, the same edge the data lands. From then on, decode's combinational read returns the new value and the busy bit is already low, so no stale-read window exists.
  - A commit to $0 or a reserved-encoding commit clears nothing.
  - Issue and clear of the same register at the same edge: issue wins and the bit stays 1, because a new producer owns it.
  - Issue to a register whose bit is already 1 (and is not being cleared that edge): bit stays 1 and err is set.
- rs_busy and rt_busy are combinational from the current pend_mask; an index of 0 always yields 0.
- retire_cnt increments by 1 at E+1 for every accepted request, including $0 and reserved ones. It wraps modulo 2^32.
- err is sticky until reset.

Test Plan:
1. Reset mid-COMMIT: accept (rd=5, ALU, alu_res=0x1234) then pull RST low before E+1 -> RegWre=0 immediately, pend_mask=0, retire_cnt=0.
2. Issue reg 8, two cycles later accept (wb_dst_sel=00, rt=8, wb_sel=01, mem_data=0xDEADBEEF):
   - rt_busy(rt_q=8)=1 until E+1.
   - RegWre=1, WriteReg=8, WriteData=0xDEADBEEF for exactly one cycle.
   - pend_mask=0 after E+1; retire_cnt=1.
3. Back-to-back accepts: JAL (wb_dst_sel=10, pc4=0x00400008) then rd=3 (ALU 0x7) -> RegWre high two consecutive cycles, WriteReg 31 then 3, bits 31 and 3 cleared on successive edges.
4. Same-edge issue and commit of reg 4 -> pend_mask[4]=1 afterwards, err=0.
5. Double issue of reg 6 without commit -> err=1 and stays 1.
6. Commit to rd=0 with alu_res=0xFFFFFFFF -> RegWre stays 0, pend_mask unchanged, retire_cnt incremented.

Source files
------------

// File: rtl/wb_scoreboard.sv
// Write-back stage of the multi-cycle MIPS CPU.
// Picks the write-back source and destination, registers the register-file
// write for one cycle, and tracks which registers still await a producer so
// decode can stall on them.
module wb_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_reg,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [1:0]        wb_sel,
   input  logic [1:0]        wb_dst_sel,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] alu_res,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] pc4,
   output logic              RegWre,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] rs_q,
   input  logic [ADDR_W-1:0] rt_q,
   output logic              rs_busy,
   output logic              rt_busy,
   output logic [31:0]       pend_mask,
   output logic [31:0]       retire_cnt,
   output logic              err
);

   localparam logic STATE_IDLE   = 1'b0;
   localparam logic STATE_COMMIT = 1'b1;

   logic              state;
   logic              accept;
   logic              reserved;
   logic [ADDR_W-1:0] dstReg;
   logic [DATA_W-1:0] dstData;
   logic              issueHit;
   logic [31:0]       setMask;
   logic [31:0]       clearMask;
   logic              doubleIssue;

   assign wb_ready = 1'b1;
   assign accept   = wb_valid && wb_ready;

   // Decode the destination/source selects; reserved codes yield zero and flag the request
   always_comb begin
      dstReg   = '0;
      dstData  = '0;
      reserved = (wb_sel == 2'b11) || (wb_dst_sel == 2'b11);
      case (wb_dst_sel)
         2'b00:   dstReg = rt;
         2'b01:   dstReg = rd;
         2'b10:   dstReg = ADDR_W'(31);
         default: dstReg = '0;
      endcase
      case (wb_sel)
         2'b00:   dstData = alu_res;
         2'b01:   dstData = mem_data;
         2'b10:   dstData = pc4;
         default: dstData = '0;
      endcase
   end

   // Scoreboard set/clear masks; the clear comes from the write landing in the register file this edge
   always_comb begin
      issueHit    = iss_en && (iss_reg != '0);
      setMask     = issueHit ? (32'd1 << iss_reg) : 32'd0;
      clearMask   = ((state == STATE_COMMIT) && RegWre) ? (32'd1 << WriteReg) : 32'd0;
      doubleIssue = issueHit && pend_mask[iss_reg] && !clearMask[iss_reg];
   end

   assign rs_busy = (rs_q != '0) && pend_mask[rs_q];
   assign rt_busy = (rt_q != '0) && pend_mask[rt_q];

   // COMMIT means a registered write is being presented to the register file this cycle
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= STATE_IDLE;
      end else if (accept) begin
         state <= STATE_COMMIT;
      end else begin
         state <= STATE_IDLE;
      end
   end

   // Register the selected write; $0 and reserved requests travel with the enable held low
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         RegWre    <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
      end else if (accept) begin
         RegWre    <= !reserved && (dstReg != '0);
         WriteReg  <= reserved ? '0 : dstReg;
         WriteData <= dstData;
      end else begin
         RegWre <= 1'b0;
      end
   end

   // Pending mask: clear the landing register, then a same-edge issue re-claims it for the new producer
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pend_mask <= '0;
      end else begin
         pend_mask <= (pend_mask & ~clearMask) | setMask;
      end
   end

   // Every accepted request retires on the edge after acceptance, whether or not it writes
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         retire_cnt <= '0;
      end else if (state == STATE_COMMIT) begin
         retire_cnt <= retire_cnt + 32'd1;
      end
   end

   // Sticky protocol error: re-issuing a still-pending register or using a reserved encoding
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         err <= 1'b0;
      end else if (doubleIssue || (accept && reserved)) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Testbench for wb_scoreboard: directed scenarios plus randomized traffic,
// with register-file writes checked through an expectation queue.
module tb_wb_scoreboard;

   logic        CLK;
   logic        RST;
   logic        iss_en;
   logic [4:0]  iss_reg;
   logic        wb_valid;
   logic        wb_ready;
   logic [1:0]  wb_sel;
   logic [1:0]  wb_dst_sel;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] alu_res;
   logic [31:0] mem_data;
   logic [31:0] pc4;
   logic        RegWre;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [4:0]  rs_q;
   logic [4:0]  rt_q;
   logic        rs_busy;
   logic        rt_busy;
   logic [31:0] pend_mask;
   logic [31:0] retire_cnt;
   logic        err;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } wr_t;

   wr_t         expQ[$];
   int          tests;
   int          fails;

   bit          mPend[32];
   int unsigned mRetire;
   bit          mErr;
   bit          inflightValid;
   bit          inflightWe;
   logic [4:0]  inflightReg;
   logic [31:0] savedRetire;

   wb_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
      .CLK(CLK), .RST(RST),
      .iss_en(iss_en), .iss_reg(iss_reg),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_sel(wb_sel), .wb_dst_sel(wb_dst_sel),
      .rt(rt), .rd(rd),
      .alu_res(alu_res), .mem_data(mem_data), .pc4(pc4),
      .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
      .rs_q(rs_q), .rt_q(rt_q), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .pend_mask(pend_mask), .retire_cnt(retire_cnt), .err(err)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] modelMask();
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) m[i] = mPend[i];
      return m;
   endfunction

   function automatic logic modelBusy(input logic [4:0] q);
      return (q != 5'd0) && mPend[q];
   endfunction

   task automatic resetModel();
      for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
      mRetire       = 0;
      mErr          = 1'b0;
      inflightValid = 1'b0;
      inflightWe    = 1'b0;
      inflightReg   = '0;
      expQ.delete();
   endtask

   task automatic idleInputs();
      iss_en     = 1'b0;
      iss_reg    = '0;
      wb_valid   = 1'b0;
      wb_sel     = 2'b00;
      wb_dst_sel = 2'b00;
   endtask

   task automatic checkOutput();
      checkVal("RegWre", {31'd0, RegWre}, {31'd0, inflightWe});
      checkVal("pend_mask", pend_mask, modelMask());
      checkVal("retire_cnt", retire_cnt, mRetire);
      checkVal("err", {31'd0, err}, {31'd0, mErr});
      checkVal("rs_busy", {31'd0, rs_busy}, {31'd0, modelBusy(rs_q)});
      checkVal("rt_busy", {31'd0, rt_busy}, {31'd0, modelBusy(rt_q)});
      checkVal("wb_ready", {31'd0, wb_ready}, 32'd1);
   endtask

   // Advance one rising edge with the inputs currently driven, updating the model to match
   task automatic applyStimulus();
      bit          clrV;
      logic [4:0]  clr;
      logic [4:0]  dst;
      logic [31:0] dat;
      bit          rsv;
      clrV = inflightWe;
      clr  = inflightReg;
      if (inflightValid) mRetire++;
      if (iss_en && iss_reg != 5'd0) begin
         if (mPend[iss_reg] && !(clrV && clr == iss_reg)) mErr = 1'b1;
      end
      if (clrV) mPend[clr] = 1'b0;
      if (iss_en && iss_reg != 5'd0) mPend[iss_reg] = 1'b1;
      if (wb_valid) begin
         rsv = (wb_sel == 2'b11) || (wb_dst_sel == 2'b11);
         dst = (wb_dst_sel == 2'b00) ? rt : (wb_dst_sel == 2'b01) ? rd : 5'd31;
         dat = (wb_sel == 2'b00) ? alu_res : (wb_sel == 2'b01) ? mem_data : pc4;
         if (rsv) mErr = 1'b1;
         inflightValid = 1'b1;
         inflightWe    = !rsv && (dst != 5'd0);
         inflightReg   = dst;
         if (inflightWe) expQ.push_back('{r: dst, d: dat});
      end else begin
         inflightValid = 1'b0;
         inflightWe    = 1'b0;
      end
      @(posedge CLK);
      #1;
      checkOutput();
   endtask

   // Assert reset in the middle of a cycle, check the immediate effect, release on a falling edge
   task automatic resetDut();
      #2;
      RST = 1'b0;
      #1;
      resetModel();
      checkVal("rst_RegWre", {31'd0, RegWre}, 32'd0);
      checkVal("rst_pend_mask", pend_mask, 32'd0);
      checkVal("rst_retire_cnt", retire_cnt, 32'd0);
      checkVal("rst_err", {31'd0, err}, 32'd0);
      checkVal("rst_WriteReg", {27'd0, WriteReg}, 32'd0);
      checkVal("rst_WriteData", WriteData, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic accept(input logic [1:0] dsel, input logic [1:0] sel,
                         input logic [4:0] rtv, input logic [4:0] rdv, input logic [31:0] data);
      wb_valid   = 1'b1;
      wb_dst_sel = dsel;
      wb_sel     = sel;
      rt         = rtv;
      rd         = rdv;
      alu_res    = data;
      mem_data   = data;
      pc4        = data;
   endtask

   // Monitor: every register-file write must match the oldest expected write
   always @(negedge CLK) begin
      if (RST === 1'b1 && RegWre === 1'b1) begin
         if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL wr_unexpected: got reg %0d data 0x%08h expected no write", WriteReg, WriteData);
         end else begin
            wr_t e;
            e = expQ.pop_front();
            checkVal("wr_reg", {27'd0, WriteReg}, {27'd0, e.r});
            checkVal("wr_data", WriteData, e.d);
         end
      end
   end

   initial begin
      tests = 0;
      fails = 0;
      RST = 1'b0;
      idleInputs();
      rt = '0; rd = '0; rs_q = '0; rt_q = '0;
      alu_res = '0; mem_data = '0; pc4 = '0;
      resetModel();
      #12;
      checkOutput();
      @(negedge CLK);
      RST = 1'b1;

      // Reset while a write is being presented
      iss_en = 1'b1; iss_reg = 5'd5; rs_q = 5'd5;
      applyStimulus();
      iss_en = 1'b0;
      accept(2'b01, 2'b00, 5'd0, 5'd5, 32'h0000_1234);
      applyStimulus();
      idleInputs();
      resetDut();

      // Issue reg 8, memory load commits two cycles later
      iss_en = 1'b1; iss_reg = 5'd8; rt_q = 5'd8;
      applyStimulus();
      iss_en = 1'b0;
      applyStimulus();
      applyStimulus();
      accept(2'b00, 2'b01, 5'd8, 5'd0, 32'hDEAD_BEEF);
      applyStimulus();
      checkVal("t2_busy_at_E", {31'd0, rt_busy}, 32'd1);
      checkVal("t2_WriteReg", {27'd0, WriteReg}, 32'd8);
      checkVal("t2_WriteData", WriteData, 32'hDEAD_BEEF);
      idleInputs();
      applyStimulus();
      checkVal("t2_busy_after", {31'd0, rt_busy}, 32'd0);
      checkVal("t2_RegWre_off", {31'd0, RegWre}, 32'd0);
      checkVal("t2_pend", pend_mask, 32'd0);
      checkVal("t2_retire", retire_cnt, 32'd1);

      // Back-to-back JAL and ALU write
      iss_en = 1'b1; iss_reg = 5'd31;
      applyStimulus();
      iss_reg = 5'd3;
      applyStimulus();
      iss_en = 1'b0;
      accept(2'b10, 2'b10, 5'd0, 5'd0, 32'h0040_0008);
      applyStimulus();
      checkVal("t3_jal_reg", {27'd0, WriteReg}, 32'd31);
      accept(2'b01, 2'b00, 5'd0, 5'd3, 32'h0000_0007);
      applyStimulus();
      checkVal("t3_alu_reg", {27'd0, WriteReg}, 32'd3);
      checkVal("t3_pend_31_cleared", pend_mask, 32'h0000_0008);
      idleInputs();
      applyStimulus();
      checkVal("t3_pend_3_cleared", pend_mask, 32'd0);

      // Same-edge issue and commit of reg 4
      iss_en = 1'b1; iss_reg = 5'd4;
      applyStimulus();
      iss_en = 1'b0;
      accept(2'b01, 2'b00, 5'd0, 5'd4, 32'h0000_0044);
      applyStimulus();
      idleInputs();
      iss_en = 1'b1; iss_reg = 5'd4;
      applyStimulus();
      iss_en = 1'b0;
      checkVal("t4_pend4", {31'd0, pend_mask[4]}, 32'd1);
      checkVal("t4_err", {31'd0, err}, 32'd0);

      // Commit to $0
      savedRetire = retire_cnt;
      accept(2'b01, 2'b00, 5'd0, 5'd0, 32'hFFFF_FFFF);
      applyStimulus();
      checkVal("t6_RegWre", {31'd0, RegWre}, 32'd0);
      idleInputs();
      applyStimulus();
      checkVal("t6_pend", pend_mask, 32'h0000_0010);
      checkVal("t6_retire", retire_cnt, savedRetire + 32'd1);

      // Randomized legal traffic
      for (int n = 0; n < 400; n++) begin
         logic [4:0] r;
         r = 5'($urandom_range(1, 31));
         iss_en  = ($urandom_range(0, 2) == 0) && !mPend[r];
         iss_reg = r;
         wb_valid   = ($urandom_range(0, 1) == 1);
         wb_sel     = 2'($urandom_range(0, 2));
         wb_dst_sel = 2'($urandom_range(0, 2));
         rt       = 5'($urandom);
         rd       = 5'($urandom);
         alu_res  = $urandom;
         mem_data = $urandom;
         pc4      = $urandom;
         rs_q     = 5'($urandom);
         rt_q     = 5'($urandom);
         applyStimulus();
      end
      idleInputs();
      applyStimulus();
      applyStimulus();
      checkVal("rand_err_clear", {31'd0, err}, 32'd0);

      // Double issue of reg 6 without commit
      if (!mPend[6]) begin
         iss_en = 1'b1; iss_reg = 5'd6;
         applyStimulus();
      end
      iss_en = 1'b1; iss_reg = 5'd6;
      applyStimulus();
      iss_en = 1'b0;
      checkVal("t5_err_set", {31'd0, err}, 32'd1);
      applyStimulus();
      applyStimulus();
      checkVal("t5_err_sticky", {31'd0, err}, 32'd1);

      // Reserved encodings still retire but never write
      savedRetire = retire_cnt;
      accept(2'b01, 2'b11, 5'd0, 5'd9, 32'h1111_2222);
      applyStimulus();
      accept(2'b11, 2'b00, 5'd9, 5'd9, 32'h3333_4444);
      applyStimulus();
      idleInputs();
      applyStimulus();
      checkVal("rsv_retire", retire_cnt, savedRetire + 32'd2);

      checkVal("queue_drained", expQ.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
